// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// STATUS bit positions and the FSM state type used by both TX and RX.
package uart_mmio_pkg;

    localparam logic [3:0] OFS_RXDATA = 4'h0;
    localparam logic [3:0] OFS_TXDATA = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_READY = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_TX_BUSY  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word fall-through output. Pointers carry one extra
// bit so full and empty can be told apart without a separate counter.
// A pop on an empty FIFO is ignored; a push on a full FIFO is only taken
// when a pop frees a slot in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Qualify push/pop against the current fill state and advance pointers.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset leaves the FIFO empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART on the core data port. Loads return registered
// data one cycle after the strobe so they can share the data-memory mux.
// Optional build macro: UART_LOOPBACK_EN feeds the RX synchronizer from
// the internal transmit line instead of the uart_rxd pin.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int          CLK_PER_BIT = 868,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Bus side
    logic [3:0]  ofs;
    logic        rd_en, wr_en;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] status_word;
    logic        status_rd;
    logic        overrun_q, overrun_d;

    // FIFOs
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;
    logic       rx_overflow;

    // Transmitter
    uart_state_t tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    // Receiver
    logic        rx_in;
    logic        rx_sync1_q, rx_sync1_d;
    logic        rx_sync2_q, rx_sync2_d;
    logic        rx_prev_q, rx_prev_d;
    uart_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;

    logic unused_bits;

`ifdef UART_LOOPBACK_EN
    assign rx_in       = txd_q;
    assign unused_bits = ^{wdata[31:8], uart_rxd};
`else
    assign rx_in       = uart_rxd;
    assign unused_bits = ^wdata[31:8];
`endif

    assign hit      = (addr[31:4] == MMIO_BASE[31:4]);
    assign ofs      = addr[3:0];
    assign rd_en    = re && hit;
    assign wr_en    = we && hit;
    assign rdata    = rdata_q;
    assign uart_txd = txd_q;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shift_q),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Assemble the STATUS word from live FIFO/FSM state and the sticky flag.
    always_comb begin
        status_word              = '0;
        status_word[ST_RX_VALID] = !rx_empty;
        status_word[ST_TX_READY] = !tx_full;
        status_word[ST_OVERRUN]  = overrun_q;
        status_word[ST_TX_BUSY]  = (tx_state_q != IDLE);
    end

    // Register decode: load data capture, RX pop, TX push and STATUS-read side effect.
    always_comb begin
        rdata_d   = rdata_q;
        rx_pop    = 1'b0;
        status_rd = 1'b0;
        tx_push   = wr_en && (ofs == OFS_TXDATA);
        if (rd_en) begin
            case (ofs)
                OFS_RXDATA: begin
                    rdata_d = rx_empty ? 32'd0 : {24'd0, rx_dout};
                    rx_pop  = 1'b1;
                end
                OFS_STATUS: begin
                    rdata_d   = status_word;
                    status_rd = 1'b1;
                end
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // Sticky overrun: a dropped RX byte sets it, a STATUS read clears it, set wins.
    always_comb begin
        rx_overflow = rx_push && rx_full && !(rx_pop && !rx_empty);
        overrun_d   = overrun_q;
        if (status_rd) begin
            overrun_d = 1'b0;
        end
        if (rx_overflow) begin
            overrun_d = 1'b1;
        end
    end

    // TX next state: fetch from FIFO in IDLE, then start, 8 data bits LSB-first, stop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // Line level follows the current TX state one cycle later, so the pin is glitch-free.
    always_comb begin
        case (tx_state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = tx_shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // RX next state: edge detect, mid-start check, mid-bit sampling, stop-bit validation.
    always_comb begin
        rx_sync1_d = rx_in;
        rx_sync2_d = rx_sync1_q;
        rx_prev_d  = rx_sync2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_cnt_d   = CNT_ONE;
                    rx_state_d = START;
                end
            end
            START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync2_q ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_push    = rx_sync2_q;
                    rx_state_d = IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // State registers; the line-facing flops reset to the idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= '0;
            overrun_q  <= 1'b0;
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rdata_q    <= rdata_d;
            overrun_q  <= overrun_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with a fast bit rate and shallow FIFOs.
module tb_uart_mmio;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        uart_rxd;
    logic        uart_txd;

    int total = 0;
    int bad   = 0;

    uart_mmio #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH),
        .MMIO_BASE   (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .re       (re),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .hit      (hit),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] o, input logic [7:0] d);
        addr  = BASE | {28'd0, o};
        wdata = {24'hABCDEF, d};
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] o, output logic [31:0] d);
        addr = BASE | {28'd0, o};
        re   = 1'b1;
        tick();
        re   = 1'b0;
        d    = rdata;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) tick();
        end
        uart_rxd = stop_bit;
        repeat (CPB) tick();
        uart_rxd = 1'b1;
        repeat (4) tick();
    endtask

    task automatic capture_tx(output logic [7:0] b, output bit ok);
        int w;
        ok = 1'b0;
        b  = 8'd0;
        w  = 0;
        while (uart_txd !== 1'b0 && w < 400) begin
            tick();
            w++;
        end
        if (uart_txd !== 1'b0) return;
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            b[i] = uart_txd;
        end
        repeat (CPB) tick();
        ok = (uart_txd === 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; uart_rxd = 1'b1;
        repeat (3) tick();
        total++;
        if (uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL reset_txd got=%b exp=1", uart_txd); end
        total++;
        if (rdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=0", rdata); end
        total++;
        if (hit !== 1'b0) begin bad++; $display("[TB] FAIL hit_outside got=%b exp=0", hit); end
        rst = 1'b0;
        tick();
        addr = BASE + 32'd8;
        #1;
        total++;
        if (hit !== 1'b1) begin bad++; $display("[TB] FAIL hit_inside got=%b exp=1", hit); end
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL reset_status got=%h exp=2", d); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        read_reg(4'hC, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("[TB] FAIL reserved_read got=%h exp=0", d); end
        read_reg(4'h8, d);
        addr = 32'h0000_0008;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        total++;
        if (rdata !== 32'h2) begin bad++; $display("[TB] FAIL unqualified_re_hold got=%h exp=2", rdata); end
        read_reg(4'h9, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("[TB] FAIL unaligned_read got=%h exp=0", d); end
        write_reg(4'hC, 8'h55);
        write_reg(4'h5, 8'h55);
        repeat (3) tick();
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL reserved_write_ignored got=%h exp=2", d); end
    endtask

    task automatic test_tx_basic();
        logic [9:0]  fr;
        logic [31:0] d;
        int          errs;
        fr = {1'b1, 8'hA5, 1'b0};
        write_reg(4'h4, 8'hA5);
        total++;
        if (uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL tx_after_store got=%b exp=1", uart_txd); end
        tick();
        total++;
        if (uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL tx_edge_n1 got=%b exp=1", uart_txd); end
        tick();
        errs = 0;
        for (int c = 0; c < 40; c++) begin
            total++;
            if (uart_txd !== fr[c / CPB]) begin
                bad++;
                errs++;
                if (errs < 4) $display("[TB] FAIL tx_frame_cycle%0d got=%b exp=%b", c, uart_txd, fr[c / CPB]);
            end
            tick();
        end
        repeat (2) tick();
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL tx_idle_status got=%h exp=2", d); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0]  got [5];
        bit          ok  [5];
        logic [31:0] st;
        logic [31:0] d;
        int          lows;
        fork
            begin
                addr = BASE + 32'd4;
                we   = 1'b1;
                for (int i = 1; i <= 6; i++) begin
                    wdata = 32'(i);
                    tick();
                end
                we = 1'b0;
                read_reg(4'h8, st);
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    capture_tx(got[j], ok[j]);
                end
            end
        join
        total++;
        if (st !== 32'h8) begin bad++; $display("[TB] FAIL ovf_status_full got=%h exp=8", st); end
        for (int j = 0; j < 5; j++) begin
            total++;
            if (!ok[j] || got[j] !== 8'(j + 1)) begin
                bad++;
                $display("[TB] FAIL ovf_byte%0d got=%h ok=%0d exp=%h", j, got[j], ok[j], 8'(j + 1));
            end
        end
        lows = 0;
        repeat (60) begin
            tick();
            if (uart_txd === 1'b0) lows++;
        end
        total++;
        if (lows !== 0) begin bad++; $display("[TB] FAIL ovf_dropped_byte low_cycles=%0d exp=0", lows); end
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL ovf_final_status got=%h exp=2", d); end
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        send_rx(8'h3C, 1'b1);
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h3) begin bad++; $display("[TB] FAIL rx_status_valid got=%h exp=3", d); end
        read_reg(4'h0, d);
        total++;
        if (d !== 32'h0000_003C) begin bad++; $display("[TB] FAIL rx_data got=%h exp=3c", d); end
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL rx_status_empty got=%h exp=2", d); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        logic [7:0]  exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4; i++) send_rx(exp_b[i], 1'b1);
        send_rx(8'h55, 1'b1);
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h7) begin bad++; $display("[TB] FAIL ovr_status_set got=%h exp=7", d); end
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h3) begin bad++; $display("[TB] FAIL ovr_status_cleared got=%h exp=3", d); end
        for (int i = 0; i < 4; i++) begin
            read_reg(4'h0, d);
            total++;
            if (d !== {24'd0, exp_b[i]}) begin bad++; $display("[TB] FAIL ovr_read%0d got=%h exp=%h", i, d, exp_b[i]); end
        end
        read_reg(4'h0, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("[TB] FAIL rx_empty_read got=%h exp=0", d); end
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL ovr_final_status got=%h exp=2", d); end
    endtask

    task automatic test_rx_framing();
        logic [31:0] d;
        uart_rxd = 1'b0;
        tick();
        uart_rxd = 1'b1;
        repeat (20) tick();
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL glitch_no_byte got=%h exp=2", d); end
        send_rx(8'h77, 1'b0);
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL framing_no_byte got=%h exp=2", d); end
        send_rx(8'h81, 1'b1);
        read_reg(4'h0, d);
        total++;
        if (d !== 32'h81) begin bad++; $display("[TB] FAIL framing_recover got=%h exp=81", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int          lows;
        send_rx(8'h99, 1'b1);
        write_reg(4'h4, 8'h00);
        write_reg(4'h4, 8'h00);
        write_reg(4'h4, 8'h00);
        repeat (12) tick();
        total++;
        if (uart_txd !== 1'b0) begin bad++; $display("[TB] FAIL txd_mid_frame got=%b exp=0", uart_txd); end
        rst = 1'b1;
        tick();
        total++;
        if (uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL txd_after_rst got=%b exp=1", uart_txd); end
        rst  = 1'b0;
        lows = 0;
        repeat (30) begin
            tick();
            if (uart_txd === 1'b0) lows++;
        end
        total++;
        if (lows !== 0) begin bad++; $display("[TB] FAIL tx_fifo_flushed low_cycles=%0d exp=0", lows); end
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL rst_status got=%h exp=2", d); end
    endtask

`ifdef UART_LOOPBACK_EN
    task automatic test_loopback();
        logic [31:0] d;
        write_reg(4'h4, 8'h5A);
        repeat (60) tick();
        read_reg(4'h0, d);
        total++;
        if (d !== 32'h5A) begin bad++; $display("[TB] FAIL loopback_data got=%h exp=5a", d); end
        read_reg(4'h8, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL loopback_status got=%h exp=2", d); end
    endtask
`endif

    initial begin
        $display("[TB] starting uart_mmio bench");
        test_reset();
`ifdef UART_LOOPBACK_EN
        test_loopback();
`else
        test_decode();
        test_tx_basic();
        test_tx_overflow();
        test_rx_basic();
        test_rx_overrun();
        test_rx_framing();
        test_reset_mid_frame();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
